// File: rtl/tdm_demux2to1b4.sv
// Receive side of the 2:1 TDM bus: rebuilds aligned A/B word pairs from the
// tagged shared bus and tracks out-of-order tags with a sticky flag and counter.
module tdm_demux2to1b4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             ctrl,
  input  logic [WIDTH-1:0] D,
  input  logic             sync,
  input  logic             err_clr,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             pair_valid,
  output logic             phase,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  state_t             cur_state_c;
  logic [WIDTH-1:0]   a_stg_q;
  logic [WIDTH-1:0]   a_stg_d;
  logic [WIDTH-1:0]   a_out_d;
  logic [WIDTH-1:0]   b_out_d;
  logic               pair_valid_d;
  logic               seq_err_c;
  logic               err_d;
  logic [CNT_W-1:0]   err_cnt_d;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_A;
      a_stg_q    <= '0;
      A_out      <= '0;
      B_out      <= '0;
      pair_valid <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      a_stg_q    <= a_stg_d;
      A_out      <= a_out_d;
      B_out      <= b_out_d;
      pair_valid <= pair_valid_d;
      err        <= err_d;
      err_cnt    <= err_cnt_d;
    end
  end

  // sync re-frames before the same-cycle word is evaluated.
  always_comb begin
    cur_state_c = sync ? WAIT_A : state_q;
  end

  // Next-state, staging and pair assembly.
  always_comb begin
    state_d      = cur_state_c;
    a_stg_d      = a_stg_q;
    a_out_d      = A_out;
    b_out_d      = B_out;
    pair_valid_d = 1'b0;
    seq_err_c    = 1'b0;

    if (in_valid) begin
      unique case (cur_state_c)
        WAIT_A: begin
          if (!ctrl) begin
            a_stg_d = D;
            state_d = WAIT_B;
          end else begin
            seq_err_c = 1'b1;
            state_d   = WAIT_A;
          end
        end
        WAIT_B: begin
          if (ctrl) begin
            a_out_d      = a_stg_q;
            b_out_d      = D;
            pair_valid_d = 1'b1;
            state_d      = WAIT_A;
          end else begin
            // Repeated A: newest word replaces the staged one.
            a_stg_d   = D;
            seq_err_c = 1'b1;
            state_d   = WAIT_B;
          end
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  // Error flag and saturating counter; a new error outranks a clear.
  always_comb begin
    err_d     = err;
    err_cnt_d = err_cnt;
    if (seq_err_c) begin
      err_d = 1'b1;
      if (err_clr) begin
        err_cnt_d = CNT_W'(1);
      end else if (err_cnt != CNT_MAX) begin
        err_cnt_d = err_cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  assign phase = (state_q == WAIT_B);

endmodule

// File: tb/tb_tdm_demux2to1b4.sv
// Directed bench for tdm_demux2to1b4: pair assembly, sequence errors, sync,
// counter saturation/clear and mid-pair reset.
module tb_tdm_demux2to1b4;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             ctrl;
  logic [WIDTH-1:0] D;
  logic             sync;
  logic             err_clr;
  logic [WIDTH-1:0] A_out;
  logic [WIDTH-1:0] B_out;
  logic             pair_valid;
  logic             phase;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  tdm_demux2to1b4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ctrl      (ctrl),
    .D         (D),
    .sync      (sync),
    .err_clr   (err_clr),
    .A_out     (A_out),
    .B_out     (B_out),
    .pair_valid(pair_valid),
    .phase     (phase),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the rising edge.
  task automatic step(input logic v, input logic c, input logic [WIDTH-1:0] d,
                      input logic s, input logic clr, input logic r);
    in_valid = v;
    ctrl     = c;
    D        = d;
    sync     = s;
    err_clr  = clr;
    rst      = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctrl     = 1'b0;
    D        = '0;
    sync     = 1'b0;
    err_clr  = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic word(input logic c, input logic [WIDTH-1:0] d);
    step(1'b1, c, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_pair(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic pv);
    chk({tag, "_a"}, 32'(A_out), 32'(a));
    chk({tag, "_b"}, 32'(B_out), 32'(b));
    chk({tag, "_pv"}, 32'(pair_valid), 32'(pv));
  endtask

  initial begin
    in_valid = 1'b0; ctrl = 1'b0; D = '0; sync = 1'b0; err_clr = 1'b0; rst = 1'b1;
    @(negedge clk);
    do_reset();
    chk_pair("rst", 4'h0, 4'h0, 1'b0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);

    // Basic pair
    word(1'b0, 4'b1100);
    chk("p1_phase_b", 32'(phase), 32'd1);
    chk("p1_pv_a", 32'(pair_valid), 32'd0);
    word(1'b1, 4'b0011);
    chk_pair("p1", 4'b1100, 4'b0011, 1'b1);
    chk("p1_phase", 32'(phase), 32'd0);
    chk("p1_err", 32'(err), 32'd0);
    idle();
    chk_pair("p1_hold", 4'b1100, 4'b0011, 1'b0);

    // Back-to-back pairs
    word(1'b0, 4'h1);
    word(1'b1, 4'h2);
    chk_pair("bb1", 4'h1, 4'h2, 1'b1);
    word(1'b0, 4'h3);
    chk_pair("bb_mid", 4'h1, 4'h2, 1'b0);
    word(1'b1, 4'h4);
    chk_pair("bb2", 4'h3, 4'h4, 1'b1);
    // Gaps between words
    idle();
    word(1'b0, 4'h5);
    idle();
    idle();
    chk("gap_phase", 32'(phase), 32'd1);
    chk_pair("gap_hold", 4'h3, 4'h4, 1'b0);
    word(1'b1, 4'h6);
    chk_pair("gap", 4'h5, 4'h6, 1'b1);
    chk("gap_err", 32'(err), 32'd0);

    // Sequence errors
    do_reset();
    word(1'b1, 4'h5);
    chk("seq_b_err", 32'(err), 32'd1);
    chk("seq_b_cnt", 32'(err_cnt), 32'd1);
    chk("seq_b_phase", 32'(phase), 32'd0);
    chk("seq_b_pv", 32'(pair_valid), 32'd0);
    word(1'b0, 4'hA);
    word(1'b0, 4'hC);
    chk("seq_aa_cnt", 32'(err_cnt), 32'd2);
    chk("seq_aa_phase", 32'(phase), 32'd1);
    word(1'b1, 4'h3);
    chk_pair("seq", 4'hC, 4'h3, 1'b1);
    chk("seq_err", 32'(err), 32'd1);
    chk("seq_cnt", 32'(err_cnt), 32'd2);

    // Sync re-framing
    do_reset();
    word(1'b0, 4'h7);
    chk("sy_phase0", 32'(phase), 32'd1);
    step(1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0);
    chk("sy_phase1", 32'(phase), 32'd1);
    chk("sy_err0", 32'(err), 32'd0);
    word(1'b1, 4'h6);
    chk_pair("sy", 4'h9, 4'h6, 1'b1);
    chk("sy_err", 32'(err), 32'd0);
    word(1'b0, 4'h2);
    step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("sy_alone_phase", 32'(phase), 32'd0);
    chk("sy_alone_err", 32'(err), 32'd0);
    chk_pair("sy_alone", 4'h9, 4'h6, 1'b0);
    word(1'b0, 4'h8);
    step(1'b1, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
    chk("sy_b_err", 32'(err), 32'd1);
    chk("sy_b_cnt", 32'(err_cnt), 32'd1);
    chk_pair("sy_b", 4'h9, 4'h6, 1'b0);

    // Counter saturation and clear
    do_reset();
    for (int i = 0; i < 254; i++) word(1'b1, 4'h0);
    chk("sat_254", 32'(err_cnt), 32'd254);
    for (int i = 0; i < 46; i++) word(1'b1, 4'h0);
    chk("sat_cnt", 32'(err_cnt), 32'd255);
    chk("sat_err", 32'(err), 32'd1);
    chk("sat_phase", 32'(phase), 32'd0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_cnt", 32'(err_cnt), 32'd0);
    word(1'b1, 4'h0);
    word(1'b1, 4'h0);
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("clr_new_err", 32'(err), 32'd1);
    chk("clr_new_cnt", 32'(err_cnt), 32'd1);

    // Reset mid-pair
    do_reset();
    word(1'b0, 4'h1);
    word(1'b1, 4'h2);
    word(1'b0, 4'hF);
    chk("mid_phase_b", 32'(phase), 32'd1);
    do_reset();
    chk_pair("mid_rst", 4'h0, 4'h0, 1'b0);
    chk("mid_rst_phase", 32'(phase), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    word(1'b1, 4'h1);
    chk("mid_b_cnt", 32'(err_cnt), 32'd1);
    chk("mid_b_err", 32'(err), 32'd1);
    chk_pair("mid_b", 4'h0, 4'h0, 1'b0);
    word(1'b0, 4'h4);
    step(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    chk_pair("rst_dom", 4'h0, 4'h0, 1'b0);
    chk("rst_dom_cnt", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
